// File: rtl/cpu_pkg.sv
// Shared CPU pipeline constants and types: datapath widths, the forwarding
// source selector and the opaque decoded-control bundle.
package cpu_pkg;

    localparam int XLEN    = 32;
    localparam int RADDR_W = 5;
    localparam int CTRL_W  = 16;

    // Operand source, listed from lowest to highest priority.
    typedef enum logic [1:0] {
        FWD_RF,
        FWD_WB,
        FWD_MEM,
        FWD_EX
    } fwd_sel_t;

    typedef logic [CTRL_W-1:0] ctrl_t;

endpackage

// File: rtl/id_ex_stage_if.sv
// ID/EX pipeline bus: ID-side fields, downstream writeback info, and the
// registered EX-side outputs. The stall_cnt signal exists only when
// ID_EX_STALL_CNT_EN is defined.
interface id_ex_stage_if;
    import cpu_pkg::*;

    logic               id_valid;
    logic [RADDR_W-1:0] id_ra;
    logic [RADDR_W-1:0] id_rb;
    logic [RADDR_W-1:0] id_rw;
    logic               id_regwr;
    logic               id_memrd;
    logic [XLEN-1:0]    id_busa;
    logic [XLEN-1:0]    id_busb;
    logic [XLEN-1:0]    id_imm;
    ctrl_t              id_ctrl;
    logic [XLEN-1:0]    ex_result;
    logic [RADDR_W-1:0] mem_rw;
    logic               mem_regwr;
    logic [XLEN-1:0]    mem_result;
    logic [RADDR_W-1:0] wb_rw;
    logic               wb_regwr;
    logic [XLEN-1:0]    wb_busw;
    logic               flush;

    logic               stall;
    logic               ex_valid;
    logic [RADDR_W-1:0] ex_rw;
    logic               ex_regwr;
    logic               ex_memrd;
    logic [XLEN-1:0]    ex_imm;
    ctrl_t              ex_ctrl;
    logic [XLEN-1:0]    ex_opa;
    logic [XLEN-1:0]    ex_opb;
`ifdef ID_EX_STALL_CNT_EN
    logic [31:0]        stall_cnt;
`endif

    // Pipeline side: drives the ID/downstream fields, observes the stage.
    modport master (
`ifdef ID_EX_STALL_CNT_EN
        input  stall_cnt,
`endif
        output id_valid, id_ra, id_rb, id_rw, id_regwr, id_memrd,
        output id_busa, id_busb, id_imm, id_ctrl, ex_result,
        output mem_rw, mem_regwr, mem_result, wb_rw, wb_regwr, wb_busw, flush,
        input  stall, ex_valid, ex_rw, ex_regwr, ex_memrd, ex_imm, ex_ctrl,
        input  ex_opa, ex_opb
    );

    // The ID/EX stage itself.
    modport slave (
`ifdef ID_EX_STALL_CNT_EN
        output stall_cnt,
`endif
        input  id_valid, id_ra, id_rb, id_rw, id_regwr, id_memrd,
        input  id_busa, id_busb, id_imm, id_ctrl, ex_result,
        input  mem_rw, mem_regwr, mem_result, wb_rw, wb_regwr, wb_busw, flush,
        output stall, ex_valid, ex_rw, ex_regwr, ex_memrd, ex_imm, ex_ctrl,
        output ex_opa, ex_opb
    );

endinterface

// File: rtl/id_ex_stage_fwd_mux.sv
// Forwarding mux for one ALU operand: compares the source register against
// EX/MEM/WB destinations and picks the youngest valid producer.
// Register 0 is never forwarded.
module fwd_mux
    import cpu_pkg::*;
(
    input  logic [RADDR_W-1:0] srcAddr,
    input  logic [XLEN-1:0]    rfData,
    input  logic               exValid,
    input  logic               exMemrd,
    input  logic               exRegwr,
    input  logic [RADDR_W-1:0] exRw,
    input  logic [XLEN-1:0]    exResult,
    input  logic               memRegwr,
    input  logic [RADDR_W-1:0] memRw,
    input  logic [XLEN-1:0]    memResult,
    input  logic               wbRegwr,
    input  logic [RADDR_W-1:0] wbRw,
    input  logic [XLEN-1:0]    wbBusw,
    output logic [XLEN-1:0]    operand
);

    fwd_sel_t sel;

    // Priority select EX > MEM > WB > regfile; a load in EX has no data yet.
    always_comb begin
        sel = FWD_RF;
        if (srcAddr != '0) begin
            if (exValid && !exMemrd && exRegwr && (exRw == srcAddr))
                sel = FWD_EX;
            else if (memRegwr && (memRw == srcAddr))
                sel = FWD_MEM;
            else if (wbRegwr && (wbRw == srcAddr))
                sel = FWD_WB;
        end
    end

    // Route the selected source onto the operand.
    always_comb begin
        operand = rfData;
        case (sel)
            FWD_EX:  operand = exResult;
            FWD_MEM: operand = memResult;
            FWD_WB:  operand = wbBusw;
            default: operand = rfData;
        endcase
    end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with operand forwarding, load-use stall/bubble
// and branch flush. Optional ID_EX_STALL_CNT_EN adds a 32-bit stall counter.
module id_ex_stage
    import cpu_pkg::*;
(
    input  logic          Clk,
    input  logic          Rst,
    id_ex_stage_if.slave  bus
);

    logic               exValidReg;
    logic [RADDR_W-1:0] exRwReg;
    logic               exRegwrReg;
    logic               exMemrdReg;
    logic [XLEN-1:0]    exImmReg;
    ctrl_t              exCtrlReg;
    logic [XLEN-1:0]    exOpaReg;
    logic [XLEN-1:0]    exOpbReg;

    logic               loadUse;
    logic [RADDR_W-1:0] srcAddr [2];
    logic [XLEN-1:0]    rfData  [2];
    logic [XLEN-1:0]    fwdData [2];

    assign srcAddr[0] = bus.id_ra;
    assign srcAddr[1] = bus.id_rb;
    assign rfData[0]  = bus.id_busa;
    assign rfData[1]  = bus.id_busb;

    // A load in EX whose result ID needs cannot be forwarded in time.
    assign loadUse = bus.id_valid && exValidReg && exMemrdReg && exRegwrReg &&
                     (exRwReg != '0) &&
                     ((exRwReg == bus.id_ra) || (exRwReg == bus.id_rb));

    // A flush kills the consumer, so there is nothing to hold upstream.
    assign bus.stall = loadUse && !bus.flush;

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_fwd
            fwd_mux u_fwd (
                .srcAddr   (srcAddr[gi]),
                .rfData    (rfData[gi]),
                .exValid   (exValidReg),
                .exMemrd   (exMemrdReg),
                .exRegwr   (exRegwrReg),
                .exRw      (exRwReg),
                .exResult  (bus.ex_result),
                .memRegwr  (bus.mem_regwr),
                .memRw     (bus.mem_rw),
                .memResult (bus.mem_result),
                .wbRegwr   (bus.wb_regwr),
                .wbRw      (bus.wb_rw),
                .wbBusw    (bus.wb_busw),
                .operand   (fwdData[gi])
            );
        end
    endgenerate

    // Pipeline register: flush and load-use both insert a bubble; data fields
    // are captured regardless since a bubble never writes back.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            exValidReg <= 1'b0;
            exRwReg    <= '0;
            exRegwrReg <= 1'b0;
            exMemrdReg <= 1'b0;
            exImmReg   <= '0;
            exCtrlReg  <= '0;
            exOpaReg   <= '0;
            exOpbReg   <= '0;
        end else begin
            exRwReg   <= bus.id_rw;
            exImmReg  <= bus.id_imm;
            exCtrlReg <= bus.id_ctrl;
            exOpaReg  <= fwdData[0];
            exOpbReg  <= fwdData[1];
            if (bus.flush || loadUse) begin
                exValidReg <= 1'b0;
                exRegwrReg <= 1'b0;
                exMemrdReg <= 1'b0;
            end else begin
                exValidReg <= bus.id_valid;
                exRegwrReg <= bus.id_valid && bus.id_regwr;
                exMemrdReg <= bus.id_valid && bus.id_memrd;
            end
        end
    end

    assign bus.ex_valid = exValidReg;
    assign bus.ex_rw    = exRwReg;
    assign bus.ex_regwr = exRegwrReg;
    assign bus.ex_memrd = exMemrdReg;
    assign bus.ex_imm   = exImmReg;
    assign bus.ex_ctrl  = exCtrlReg;
    assign bus.ex_opa   = exOpaReg;
    assign bus.ex_opb   = exOpbReg;

`ifdef ID_EX_STALL_CNT_EN
    logic [31:0] stallCntReg;

    // Count cycles spent stalled; wraps naturally at 32 bits.
    always_ff @(posedge Clk) begin
        if (Rst)
            stallCntReg <= '0;
        else if (bus.stall)
            stallCntReg <= stallCntReg + 32'd1;
    end

    assign bus.stall_cnt = stallCntReg;
`endif

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed testbench for id_ex_stage: reset, forwarding priority, load-use
// stall, flush, r0 handling, WB forwarding and (with ID_EX_STALL_CNT_EN)
// the stall counter.
module tb_id_ex_stage;
    import cpu_pkg::*;

    logic Clk = 1'b0;
    logic Rst;
    int   tests = 0;
    int   fails = 0;

    id_ex_stage_if bus ();

    id_ex_stage dut (
        .Clk (Clk),
        .Rst (Rst),
        .bus (bus)
    );

    always #5 Clk = ~Clk;

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance one clock and settle just after the edge.
    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic idle();
        bus.id_valid = 0; bus.id_ra = 0; bus.id_rb = 0; bus.id_rw = 0;
        bus.id_regwr = 0; bus.id_memrd = 0; bus.id_busa = 0; bus.id_busb = 0;
        bus.id_imm = 0; bus.id_ctrl = 0; bus.ex_result = 0;
        bus.mem_rw = 0; bus.mem_regwr = 0; bus.mem_result = 0;
        bus.wb_rw = 0; bus.wb_regwr = 0; bus.wb_busw = 0; bus.flush = 0;
    endtask

    // Load r5 followed by a consumer of r5 on operand A or B.
    task automatic loadUseEvent(input bit useA);
        bus.id_valid = 1; bus.id_rw = 5; bus.id_regwr = 1; bus.id_memrd = 1;
        bus.id_ra = 0; bus.id_rb = 0; bus.mem_regwr = 0; bus.wb_regwr = 0;
        tick();
        chk("lu_ex_memrd", 32'(bus.ex_memrd), 32'd1);
        bus.id_memrd = 0; bus.id_rw = 8;
        bus.id_ra = useA ? 5'd5 : 5'd1;
        bus.id_rb = useA ? 5'd2 : 5'd5;
        bus.id_busa = 32'h12; bus.id_busb = 32'h77;
        #1;
        chk("lu_stall", 32'(bus.stall), 32'd1);
        tick();
        chk("lu_bubble_valid", 32'(bus.ex_valid), 32'd0);
        chk("lu_bubble_memrd", 32'(bus.ex_memrd), 32'd0);
        chk("lu_stall_once", 32'(bus.stall), 32'd0);
        bus.mem_rw = 5; bus.mem_regwr = 1; bus.mem_result = 32'hDEAD;
        tick();
        chk("lu_retry_valid", 32'(bus.ex_valid), 32'd1);
        chk("lu_retry_opa", bus.ex_opa, useA ? 32'hDEAD : 32'h12);
        chk("lu_retry_opb", bus.ex_opb, useA ? 32'h77 : 32'hDEAD);
        bus.mem_regwr = 0;
    endtask

    initial begin
        idle();
        // 1: reset holds everything clear even with a valid ID instruction.
        Rst = 1; bus.id_valid = 1; bus.id_regwr = 1; bus.id_rw = 3;
        bus.id_ra = 1; bus.id_rb = 2; bus.id_busa = 32'hAA; bus.id_busb = 32'hBB;
        bus.id_imm = 32'h1234; bus.id_ctrl = 16'hBEEF;
        tick();
        tick();
        chk("rst_ex_valid", 32'(bus.ex_valid), 32'd0);
        chk("rst_ex_regwr", 32'(bus.ex_regwr), 32'd0);
        chk("rst_ex_memrd", 32'(bus.ex_memrd), 32'd0);
        chk("rst_ex_rw", 32'(bus.ex_rw), 32'd0);
        chk("rst_ex_opa", bus.ex_opa, 32'd0);
        chk("rst_ex_opb", bus.ex_opb, 32'd0);
        chk("rst_ex_imm", bus.ex_imm, 32'd0);
        chk("rst_ex_ctrl", 32'(bus.ex_ctrl), 32'd0);
        chk("rst_stall", 32'(bus.stall), 32'd0);
`ifdef ID_EX_STALL_CNT_EN
        chk("rst_stall_cnt", bus.stall_cnt, 32'd0);
`endif
        Rst = 0;
        tick();
        chk("rel_ex_valid", 32'(bus.ex_valid), 32'd1);
        chk("rel_ex_rw", 32'(bus.ex_rw), 32'd3);
        chk("rel_ex_opa", bus.ex_opa, 32'hAA);
        chk("rel_ex_opb", bus.ex_opb, 32'hBB);
        chk("rel_ex_imm", bus.ex_imm, 32'h1234);
        chk("rel_ex_ctrl", 32'(bus.ex_ctrl), 32'hBEEF);

        // 2: EX forwarding, EX beats MEM, MEM alone.
        bus.id_ra = 3; bus.id_busa = 32'h99; bus.id_rw = 4; bus.ex_result = 32'h11;
        tick();
        chk("fwd_ex_opa", bus.ex_opa, 32'h11);
        chk("fwd_ex_opb_rf", bus.ex_opb, 32'hBB);
        bus.id_ra = 4; bus.id_rw = 3;
        bus.mem_rw = 4; bus.mem_regwr = 1; bus.mem_result = 32'h22;
        tick();
        chk("fwd_ex_over_mem", bus.ex_opa, 32'h11);
        bus.id_ra = 6; bus.id_rw = 1; bus.mem_rw = 6;
        tick();
        chk("fwd_mem_opa", bus.ex_opa, 32'h22);
        bus.mem_regwr = 0;

        // 3: load-use stall, bubble and retry with MEM forwarding.
        loadUseEvent(1'b0);
`ifdef ID_EX_STALL_CNT_EN
        chk("cnt_after_one", bus.stall_cnt, 32'd1);
`endif

        // 4: flush concurrent with load-use.
        bus.id_valid = 1; bus.id_rw = 5; bus.id_regwr = 1; bus.id_memrd = 1;
        bus.id_ra = 0; bus.id_rb = 0;
        tick();
        bus.id_memrd = 0; bus.id_rb = 5; bus.id_rw = 8; bus.flush = 1;
        #1;
        chk("flush_stall", 32'(bus.stall), 32'd0);
        tick();
        chk("flush_valid", 32'(bus.ex_valid), 32'd0);
        chk("flush_regwr", 32'(bus.ex_regwr), 32'd0);
        chk("flush_memrd", 32'(bus.ex_memrd), 32'd0);
        bus.flush = 0; bus.id_rb = 0; bus.id_rw = 9;
        #1;
        chk("post_flush_stall", 32'(bus.stall), 32'd0);
        tick();
        chk("post_flush_valid", 32'(bus.ex_valid), 32'd1);
        chk("post_flush_rw", 32'(bus.ex_rw), 32'd9);

        // 5: register 0 is never forwarded from any stage.
        bus.id_rw = 0; bus.id_regwr = 1;
        tick();
        bus.id_rw = 10; bus.id_ra = 0; bus.id_rb = 0; bus.id_busa = 0; bus.id_busb = 0;
        bus.ex_result = 32'hFFFF;
        bus.mem_rw = 0; bus.mem_regwr = 1; bus.mem_result = 32'hFFFF;
        bus.wb_rw = 0; bus.wb_regwr = 1; bus.wb_busw = 32'hFFFF;
        tick();
        chk("r0_opa", bus.ex_opa, 32'd0);
        chk("r0_opb", bus.ex_opb, 32'd0);
        bus.mem_regwr = 0;

        // 6: WB forwarding over a stale regfile value, then MEM beats WB.
        bus.id_rw = 11; bus.id_ra = 7; bus.id_rb = 7;
        bus.wb_rw = 7; bus.wb_regwr = 1; bus.wb_busw = 32'h55;
        tick();
        chk("wb_opa", bus.ex_opa, 32'h55);
        chk("wb_opb", bus.ex_opb, 32'h55);
        bus.id_rw = 12; bus.mem_rw = 7; bus.mem_regwr = 1; bus.mem_result = 32'h66;
        tick();
        chk("mem_over_wb", bus.ex_opa, 32'h66);
        bus.mem_regwr = 0; bus.wb_regwr = 0;

        loadUseEvent(1'b1);
        loadUseEvent(1'b0);
`ifdef ID_EX_STALL_CNT_EN
        chk("cnt_after_three", bus.stall_cnt, 32'd3);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
